// File: rtl/tdes_ctrl.sv
// tdes_ctrl: sequences one Triple-DES request through an external,
// combinational single-DES core. It runs three passes (E-D-E for encrypt,
// D-E-D for decrypt) and gives each pass PASS_CYCLES cycles to settle.
// 64-bit buses: bit 63 here is bit 1 (MSB) of the DES [1:64] numbering.
// Optional feature: define TDES_DECRYPT_EN to add the mode port and the
// decrypt key sequence. Without it, every request is encrypted.
module tdes_ctrl #(
    parameter int PASS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] message,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
`ifdef TDES_DECRYPT_EN
    input  logic        mode,
`endif
    output logic [63:0] des_msg,
    output logic [63:0] des_key,
    output logic        des_decrypt,
    input  logic [63:0] des_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, PASS1, PASS2, PASS3, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(PASS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [63:0] data_q;
    logic [63:0] msg_q;
    logic [63:0] key_q;
    logic        dec_q;
    logic [63:0] key_mid_q;   // key for pass 2 (always key2)
    logic [63:0] key_last_q;  // key for pass 3 (key3 encrypt, key1 decrypt)
    logic        mode_q;
    logic        mode_in;
    logic        pass_end;
    logic        accept;

`ifdef TDES_DECRYPT_EN
    assign mode_in = mode;
`else
    assign mode_in = 1'b0;
`endif

    assign pass_end = (cnt_q == CNT_LAST);
    assign accept   = in_valid && in_ready;

    // The core sees registered copies so they stay put for the whole pass and
    // keep their last value in IDLE/DONE.
    assign des_msg     = msg_q;
    assign des_key     = key_q;
    assign des_decrypt = dec_q;
    assign result      = data_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = PASS1;
            end
            PASS1: if (pass_end) state_d = PASS2;
            PASS2: if (pass_end) state_d = PASS3;
            PASS3: if (pass_end) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-pass settle counter; restarts at every pass boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == PASS1 || state_q == PASS2 || state_q == PASS3) begin
            cnt_q <= pass_end ? 4'd0 : cnt_q + 4'd1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Request capture and hand-off of each pass result to the next pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            msg_q      <= '0;
            key_q      <= '0;
            dec_q      <= 1'b0;
            key_mid_q  <= '0;
            key_last_q <= '0;
            mode_q     <= 1'b0;
        end else if (accept) begin
            data_q     <= message;
            msg_q      <= message;
            key_q      <= mode_in ? key3 : key1;
            dec_q      <= mode_in;
            key_mid_q  <= key2;
            key_last_q <= mode_in ? key1 : key3;
            mode_q     <= mode_in;
        end else if (pass_end) begin
            case (state_q)
                PASS1: begin
                    data_q <= des_result;
                    msg_q  <= des_result;
                    key_q  <= key_mid_q;
                    dec_q  <= !mode_q;
                end
                PASS2: begin
                    data_q <= des_result;
                    msg_q  <= des_result;
                    key_q  <= key_last_q;
                    dec_q  <= mode_q;
                end
                PASS3: data_q <= des_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdes_ctrl.sv
// Testbench for tdes_ctrl. A stand-in invertible "DES" core is modelled
// combinationally. The reference model composes three core calls from the
// request fields. A driver issues requests and queues the expectations, and a
// monitor checks latency, the per-cycle key/direction trace, handshakes and
// the results.
module tb_tdes_ctrl;

    localparam int P = 2;
    localparam logic [63:0] KC = 64'h9E3779B97F4A7C15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] message, key1, key2, key3;
    logic        mode;
    logic [63:0] des_msg, des_key, des_result, result;
    logic        des_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    always #5 clk = ~clk;

    tdes_ctrl #(.PASS_CYCLES(P)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .message(message), .key1(key1), .key2(key2), .key3(key3),
`ifdef TDES_DECRYPT_EN
        .mode(mode),
`endif
        .des_msg(des_msg), .des_key(des_key), .des_decrypt(des_decrypt),
        .des_result(des_result), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    // Stand-in core: decrypt is the exact inverse of encrypt under the same key.
    function automatic logic [63:0] core_f(logic [63:0] m, logic [63:0] k, logic d);
        logic [63:0] x;
        if (!d) return ({m[58:0], m[63:59]} ^ k) + KC;
        x = (m - KC) ^ k;
        return {x[4:0], x[63:5]};
    endfunction

    always_comb des_result = core_f(des_msg, des_key, des_decrypt);

    typedef struct {
        logic [63:0] res;
        logic [63:0] ka, kb, kc;
        logic        md;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] tr_key[$];
    logic        tr_dec[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          stall = 1'b0;
    bit          prev_ov = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: 3DES as a keyed sequence of three core passes.
    function automatic exp_t model(logic [63:0] m, logic [63:0] k1, logic [63:0] k2,
                                   logic [63:0] k3, logic md);
        exp_t e;
        e.md = md;
        e.ka = md ? k3 : k1;
        e.kb = k2;
        e.kc = md ? k1 : k3;
        e.res = core_f(core_f(core_f(m, e.ka, md), e.kb, !md), e.kc, md);
        e.acc = 0;
        return e;
    endfunction

    // Consumer back-pressure, changed away from both clock edges.
    always @(posedge clk) begin
        #2;
        out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: trace collection, latency, key sequence, result and handshakes.
    always @(negedge clk) begin
        if (rst) begin
            tr_key.delete();
            tr_dec.delete();
            prev_ov = 1'b0;
        end else begin
            if (busy && !out_valid) begin
                tr_key.push_back(des_key);
                tr_dec.push_back(des_decrypt);
            end
            if (out_valid) begin
                chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    if (!prev_ov) begin
                        chk("latency", 64'(cyc - exp_q[0].acc), 64'(3 * P));
                        chk("trace_len", 64'(tr_key.size()), 64'(3 * P));
                        for (int i = 0; i < tr_key.size() && i < 3 * P; i++) begin
                            logic [63:0] ek;
                            logic        ed;
                            ek = (i / P == 0) ? exp_q[0].ka : (i / P == 1) ? exp_q[0].kb : exp_q[0].kc;
                            ed = exp_q[0].md ^ (i / P == 1);
                            chk($sformatf("des_key[%0d]", i), tr_key[i], ek);
                            chk($sformatf("des_decrypt[%0d]", i), {63'd0, tr_dec[i]}, {63'd0, ed});
                        end
                        tr_key.delete();
                        tr_dec.delete();
                    end
                    chk("des_key_hold_done", des_key, exp_q[0].kc);
                    chk("result", result, exp_q[0].res);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic chk_reset_state();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_des_msg", des_msg, 64'd0);
        chk("rst_des_key", des_key, 64'd0);
        chk("rst_des_decrypt", {63'd0, des_decrypt}, 64'd0);
    endtask

    // Issue one request, wait (bounded) for acceptance, then scramble inputs.
    task automatic send(logic [63:0] m, logic [63:0] k1, logic [63:0] k2,
                        logic [63:0] k3, logic md);
        exp_t e;
        int   n;
        @(negedge clk);
        message = m; key1 = k1; key2 = k2; key3 = k3; mode = md;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
`ifdef TDES_DECRYPT_EN
        e = model(m, k1, k2, k3, md);
`else
        e = model(m, k1, k2, k3, 1'b0);
`endif
        e.acc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        message = {$urandom, $urandom};
        key1 = {$urandom, $urandom};
        key2 = {$urandom, $urandom};
        key3 = {$urandom, $urandom};
        mode = 1'($urandom);
    endtask

    task automatic send_rand();
        send({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 1'($urandom));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        message = '0; key1 = '0; key2 = '0; key3 = '0; mode = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;

        // Known-answer style request, then each direction explicitly.
        send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1,
             64'h133457799BBCDFF1, 1'b0);
        send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1,
             64'h133457799BBCDFF1, 1'b1);
        send(64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 1'b0);
        send(64'h0, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'hFFFFFFFFFFFFFFFF, 1'b1);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 30; i++) send_rand();
        drain();

        // Long stall in DONE: result must hold, stray requests must be refused.
        stall = 1'b1;
        send_rand();
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            message = {$urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0;
        stall = 1'b0;
        drain();

        // Reset in the middle of the second pass discards the request.
        send_rand();
        repeat (P + 1) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state();
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2 * P + 2) @(negedge clk);
        chk("no_out_after_rst", {63'd0, out_valid}, 64'd0);

        // Recovery: normal requests complete afterwards.
        for (int i = 0; i < 4; i++) send_rand();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdes_ctrl.md
TDES_CTRL -- requirements
Module: tdes_ctrl

Interface
REQ-001 Parameter PASS_CYCLES, default 1, cycles allotted per DES core pass (legal 1..15); settle margin for the combinational core.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  request present on message/key1/key2/key3.
REQ-005 in_ready  output  1  controller can accept a request.
REQ-006 message  input  64  [1:64], bit 1 = MSB; input block.
REQ-007 key1, key2, key3  input  64 each  [1:64]; 3DES keys.
REQ-008 mode  input  1  0 = encrypt, 1 = decrypt; present only when TDES_DECRYPT_EN is defined.
REQ-009 des_msg  output  64  [1:64]; block driven to the external Single DES core.
REQ-010 des_key  output  64  [1:64]; key driven to the core.
REQ-011 des_decrypt  output  1  core direction select, 1 = decrypt.
REQ-012 des_result  input  64  [1:64]; combinational core output.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 result  output  64  [1:64]; final 3DES block.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, PASS1, PASS2, PASS3, DONE.
REQ-018 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 IDLE: on in_valid && in_ready at edge, register message into data register, key1..key3 (and mode) into key registers; go PASS1, pass counter = 0.
REQ-020 In PASSn, des_msg = data register; des_key and des_decrypt per REQ-021/REQ-022; both held stable for the whole pass.
REQ-021 Encrypt (mode 0): PASS1 = E(key1), PASS2 = D(key2), PASS3 = E(key3).
REQ-022 Decrypt (mode 1): PASS1 = D(key3), PASS2 = E(key2), PASS3 = D(key1).
REQ-023 Pass counter increments every cycle within a pass; at edge with counter == PASS_CYCLES-1, capture des_result into data register, clear counter, advance to next state (PASS3 -> DONE).
REQ-024 Latency: out_valid rises exactly 3*PASS_CYCLES cycles after the accepting edge.
REQ-025 result = data register; stable while out_valid && !out_ready.
REQ-026 DONE: on out_ready, go IDLE; no new request accepted in the same cycle (in_ready low in DONE).
REQ-027 Inputs message/key*/mode are ignored outside the accepting edge; changes mid-operation have no effect.
REQ-028 In IDLE and DONE, des_msg/des_key/des_decrypt hold their last value (no toggling).

Reset
REQ-029 rst asserted at any time, including mid-pass, immediately forces IDLE, counter 0, in_ready 1, out_valid 0, busy 0, result/des_msg/des_key all zero, des_decrypt 0; in-flight request discarded.
REQ-030 First acceptance possible at first rising edge with rst low.

Configuration
REQ-031 Macro TDES_DECRYPT_EN: defined -> mode port exists and REQ-022 sequence is supported.
REQ-032 Undefined -> no mode port; controller always runs the REQ-021 encrypt sequence.

Verification
REQ-033 key1=key2=key3=64'h133457799BBCDFF1, message=64'h0123456789ABCDEF, encrypt, PASS_CYCLES=1 -> result 64'h85E813540F0AB405, out_valid 3 cycles after accept.
REQ-034 Same keys, mode=1, message=64'h85E813540F0AB405 (TDES_DECRYPT_EN) -> result 64'h0123456789ABCDEF.
REQ-035 PASS_CYCLES=2, any request -> out_valid exactly 6 cycles after accept; des_key sequence key1,key1,key2,key2,key3,key3, des_decrypt 0,0,1,1,0,0.
REQ-036 out_ready held low 5 cycles in DONE -> result, out_valid stable; in_ready low; in_valid pulses ignored; accept again only after return to IDLE.
REQ-037 rst pulsed during PASS2 -> outputs at reset values at once, no out_valid for that request; next request completes normally.
REQ-038 message/key1 changed during PASS1 -> result matches values captured at accept.
